// File: rtl/fsm_pkg.sv
// Shared definitions for the serial sequence-detection path: state encoding,
// default word geometry and a counter-width helper.
package fsm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 1;

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Holds each serial bit for DIV cycles; tick marks the last cycle of a bit,
// tick_next predicts that the following cycle will be such a last cycle.
module bit_timer
  import fsm_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick,
  output logic tick_next
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'((DIV > 1) ? (DIV - 2) : 0);
  localparam logic [CW-1:0] ZERO     = {CW{1'b0}};

  logic [CW-1:0] cnt_r;

  // Cycle-in-bit counter, parked at zero whenever the driver is not shifting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= ZERO;
    end else if (!en) begin
      cnt_r <= ZERO;
    end else if (cnt_r == LAST) begin
      cnt_r <= ZERO;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // With DIV=1 every shifting cycle is a last cycle, so the look-ahead is constant.
  always_comb begin
    tick = en && (cnt_r == LAST);
    if (DIV == 1) begin
      tick_next = 1'b1;
    end else begin
      tick_next = en && (cnt_r == PRE_LAST);
    end
  end

endmodule

// File: rtl/serial_pattern_driver.sv
// Parallel-to-serial pattern driver: accepts a word on load/ready and shifts it
// out MSB-first on x, one bit per DIV clocks, with zero-gap back-to-back words.
module serial_pattern_driver
  import fsm_pkg::*;
#(
  parameter int   WIDTH    = DEF_WIDTH,
  parameter int   DIV      = DEF_DIV,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0]    BIT_ZERO = {BW{1'b0}};
  localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] shift_r, shift_nxt_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic             x_r, busy_r, done_r;
  logic             shifting_s, tick_s, tick_next_s, last_s, accept_s;
  logic             x_nxt_s, busy_nxt_s, done_nxt_s;

  assign shifting_s = (state_r == ST_SHIFT);

  bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .en        (shifting_s),
    .tick      (tick_s),
    .tick_next (tick_next_s)
  );

  // Handshake: the last cycle of a word doubles as an accept window.
  always_comb begin
    last_s   = shifting_s && (bit_cnt_r == BIT_LAST) && tick_s;
    ready    = !shifting_s || last_s;
    accept_s = load && ready;
  end

  // Next state, shift register and bit counter; registered outputs are
  // derived from the next state so x/busy/done line up with the bit shown.
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s   = ST_SHIFT;
          shift_nxt_s   = data_in;
          bit_cnt_nxt_s = BIT_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (accept_s) begin
          state_nxt_s   = ST_SHIFT;
          shift_nxt_s   = data_in;
          bit_cnt_nxt_s = BIT_ZERO;
        end else if (last_s) begin
          state_nxt_s   = ST_IDLE;
          shift_nxt_s   = WORD_ZERO;
          bit_cnt_nxt_s = BIT_ZERO;
        end else if (tick_s) begin
          shift_nxt_s   = shift_r << 1;
          bit_cnt_nxt_s = bit_cnt_r + BW'(1);
        end else begin
          shift_nxt_s = shift_r;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        shift_nxt_s   = WORD_ZERO;
        bit_cnt_nxt_s = BIT_ZERO;
      end
    endcase

    if (state_nxt_s == ST_SHIFT) begin
      x_nxt_s    = shift_nxt_s[WIDTH-1];
      busy_nxt_s = 1'b1;
      done_nxt_s = (bit_cnt_nxt_s == BIT_LAST) && tick_next_s;
    end else begin
      x_nxt_s    = IDLE_BIT;
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
    end
  end

  // State and output registers; reset aborts any word without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= WORD_ZERO;
      bit_cnt_r <= BIT_ZERO;
      x_r       <= IDLE_BIT;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      x_r       <= x_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign x    = x_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
